serial_cmp_ctrl: RTL and testbench

SERIAL_CMP_CTRL -- requirements
Module: serial_cmp_ctrl

---
 rtl/cmp_pkg.sv | 17 +
 rtl/bcs_cell.sv | 18 +
 rtl/serial_cmp_ctrl.sv | 137 +++++++++++++
 tb/tb_serial_cmp_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared types and constants for the serial magnitude comparator.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  function automatic bit width_ok(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/bcs_cell.sv
// One MSB-first bit slice of the comparator chain: e tracks "equal so far",
// g tracks "a below b so far".
module bcs_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic e_in,
  input  logic g_in,
  output logic e_out,
  output logic g_out
);

  // Once an earlier (more significant) slice differs, e drops and freezes g.
  always_comb begin
    e_out = e_in & ~(a_i ^ b_i);
    g_out = g_in | (~a_i & b_i & e_in);
  end

endmodule

// File: rtl/serial_cmp_ctrl.sv
// Bit-serial unsigned comparator controller (IDLE/RUN/DONE), one slice per cycle.
// Optional macro SERIAL_CMP_EARLY_EXIT_EN finishes as soon as the operands differ.
module serial_cmp_ctrl
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (!width_ok(WIDTH)) begin : g_width_check
    $error("serial_cmp_ctrl: WIDTH out of range");
  end

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IDX_W-1:0] idx_q;
  logic             e_q;
  logic             g_q;
  logic             busy_q;
  logic             done_q;
  logic             eq_q;
  logic             lt_q;
  logic             gt_q;

  logic             a_bit_s;
  logic             b_bit_s;
  logic             e_d;
  logic             g_d;
  logic             accept_s;
  logic             last_slice_s;

  bcs_cell u_cell (
    .a_i   (a_bit_s),
    .b_i   (b_bit_s),
    .e_in  (e_q),
    .g_in  (g_q),
    .e_out (e_d),
    .g_out (g_d)
  );

  // Slice selection, start acceptance and RUN termination condition.
  always_comb begin
    a_bit_s  = a_q[idx_q];
    b_bit_s  = b_q[idx_q];
    accept_s = start && (state_q != RUN);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    last_slice_s = (idx_q == IDX_W'(0)) || !e_d;
`else
    last_slice_s = (idx_q == IDX_W'(0));
`endif
  end

  // Controller FSM with all outputs registered; a start in DONE re-enters RUN directly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      e_q     <= 1'b0;
      g_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else if (accept_s) begin
      state_q <= RUN;
      a_q     <= a;
      b_q     <= b;
      idx_q   <= IDX_W'(WIDTH - 1);
      e_q     <= 1'b1;
      g_q     <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        RUN: begin
          e_q <= e_d;
          g_q <= g_d;
          if (last_slice_s) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            eq_q    <= e_d;
            lt_q    <= g_d;
            gt_q    <= ~e_d & ~g_d;
          end else begin
            state_q <= RUN;
            idx_q   <= idx_q - IDX_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          eq_q    <= 1'b0;
          lt_q    <= 1'b0;
          gt_q    <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign eq   = eq_q;
  assign lt   = lt_q;
  assign gt   = gt_q;

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Self-checking bench for serial_cmp_ctrl: vector table plus scoreboard of
// expected {eq,lt,gt} and latency, with hand sequences for multi-cycle corners.
module tb_serial_cmp_ctrl;

  localparam int W = 8;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, eq, lt, gt;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   res;
  } vec_t;

  typedef struct {
    logic [2:0] res;
    int         lat;
    int         acc;
  } exp_t;

  vec_t vecs[10];
  exp_t sb_q[$];

  serial_cmp_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .eq    (eq),
    .lt    (lt),
    .gt    (gt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic logic [2:0] model_res(input logic [W-1:0] x, input logic [W-1:0] y);
    return {x == y, x < y, x > y};
  endfunction

  function automatic int model_lat(input logic [W-1:0] x, input logic [W-1:0] y);
    int first = W;
    for (int i = W - 1; i >= 0; i--) begin
      if (x[i] != y[i] && first == W) first = W - i;
    end
    return EARLY ? first : W;
  endfunction

  // Drive a start at a negedge, wait for the accepting edge, optionally record expectations.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input bit track);
    @(negedge clk);
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (track) sb_q.push_back('{model_res(x, y), model_lat(x, y), cyc});
  endtask

  // Wait for done (bounded), compare against the scoreboard head.
  task automatic wait_done(input string name, input bit keep_start,
                           input logic [W-1:0] na, input logic [W-1:0] nb);
    bit   seen = 1'b0;
    exp_t e;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (i == 0) begin
        if (!keep_start) start = 1'b0;
        a = na;
        b = nb;
        check({name, " cleared"}, {eq, lt, gt}, 3'b000);
      end
      if (done) seen = 1'b1;
      else check({name, " busy"}, busy, 1'b1);
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s timeout: got no done want done within 40 cycles", name);
    end else if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s scoreboard: got done want no done", name);
    end else begin
      e = sb_q.pop_front();
      check({name, " latency"}, cyc - e.acc, e.lat);
      check({name, " result"}, {eq, lt, gt}, e.res);
      check({name, " busy at done"}, busy, 1'b0);
      check({name, " onehot"}, $countones({eq, lt, gt}), 1);
    end
  endtask

  logic [2:0] held;

  initial begin
    vecs[0] = '{8'h5A, 8'h5A, 3'b100};
    vecs[1] = '{8'h80, 8'h7F, 3'b001};
    vecs[2] = '{8'h00, 8'h01, 3'b010};
    vecs[3] = '{8'hFF, 8'h00, 3'b001};
    vecs[4] = '{8'h00, 8'hFF, 3'b010};
    vecs[5] = '{8'h80, 8'h00, 3'b001};
    vecs[6] = '{8'h01, 8'h00, 3'b001};
    vecs[7] = '{8'hFE, 8'hFF, 3'b010};
    vecs[8] = '{8'h00, 8'h00, 3'b100};
    vecs[9] = '{8'hFF, 8'hFF, 3'b100};

    // Reset, with start asserted to show reset wins.
    rst_n = 1'b0;
    start = 1'b1;
    a = 8'h5A;
    b = 8'h5A;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset outputs", {busy, done, eq, lt, gt}, 5'b00000);
    rst_n = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("idle outputs", {busy, done, eq, lt, gt}, 5'b00000);

    // Table vectors; operands are scrambled after the accepting edge.
    for (int v = 0; v < 10; v++) begin
      check($sformatf("vec%0d table", v), model_res(vecs[v].a, vecs[v].b), vecs[v].res);
      issue(vecs[v].a, vecs[v].b, 1'b1);
      wait_done($sformatf("vec%0d", v), 1'b0, ~vecs[v].a, vecs[v].a);
      held = vecs[v].res;
      repeat (2) @(negedge clk);
      check($sformatf("vec%0d hold", v), {busy, done, eq, lt, gt}, {2'b00, held});
    end

    // Back-to-back: start held; second operands presented during the first run.
    issue(8'h5A, 8'h5A, 1'b1);
    wait_done("b2b first", 1'b1, 8'h00, 8'h01);
    @(posedge clk);
    #1;
    sb_q.push_back('{model_res(8'h00, 8'h01), model_lat(8'h00, 8'h01), cyc});
    wait_done("b2b second", 1'b0, 8'h00, 8'h01);
    @(negedge clk);
    check("b2b pulse width", done, 1'b0);

    // Start pulsed while busy must be ignored.
    issue(8'h80, 8'h7F, 1'b1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 8'h00;
    b = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy start", 1'b0, 8'h00, 8'hFF);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("busy start no rerun", {busy, done, eq, lt, gt}, 5'b00001);
    end

    // Reset in the middle of RUN: abort, no done afterwards.
    issue(8'h5A, 8'h5A, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid reset outputs", {busy, done, eq, lt, gt}, 5'b00000);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("mid reset quiet", {busy, done}, 2'b00);
    end
    issue(8'h00, 8'h01, 1'b1);
    wait_done("after reset", 1'b0, 8'hFF, 8'h00);

    check("scoreboard empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
